seg_scan_driver: RTL



---
 rtl/traffic_pkg.sv | 60 ++++++
 rtl/bin2bcd_seq.sv | 101 ++++++++++
 rtl/seg_scan_driver.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light display path.
// Provides channel/time widths, channel indices, active-low seven-segment
// codes, the conversion FSM state type and a digit-to-segment encoder.
package traffic_pkg;

    localparam int unsigned NUM_CH  = 8;
    localparam int unsigned TIME_W  = 10;
    localparam int unsigned NUM_DIG = 2 * NUM_CH;
    localparam int unsigned NIB_W   = 4;

    localparam int unsigned CH_N  = 0;
    localparam int unsigned CH_E  = 1;
    localparam int unsigned CH_S  = 2;
    localparam int unsigned CH_W  = 3;
    localparam int unsigned CH_NL = 4;
    localparam int unsigned CH_EL = 5;
    localparam int unsigned CH_SL = 6;
    localparam int unsigned CH_WL = 7;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low, dp always off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_STORE
    } conv_state_e;

    // Decimal digit to segment code; non-decimal nibbles show blank.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   bin               TIME_W-bit binary value, sampled when start = 1
//   start             begin a conversion
//   done              one-cycle pulse in the 10th cycle after start
//   hundreds/tens/units  result digits, valid from the cycle after done
// One add-3/shift step per cycle. A thousands nibble is kept internally;
// values of 1000 and above report hundreds = 4'hF so that a non-zero
// hundreds digit always marks a value outside the two-digit range.
module bin2bcd_seq
    import traffic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] bin,
    input  logic              start,
    output logic              done,
    output logic [3:0]        hundreds,
    output logic [3:0]        tens,
    output logic [3:0]        units
);

    localparam int unsigned NUM_NIB = 4;
    localparam int unsigned SR_W    = TIME_W + NUM_NIB * NIB_W;
    localparam int unsigned CNT_W   = 4;

    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              done_q, done_d;
    logic [3:0]        hund_q, hund_d;
    logic [3:0]        tens_q, tens_d;
    logic [3:0]        units_q, units_d;
    logic [SR_W-1:0]   sr_adj;
    logic [SR_W-1:0]   sr_shift;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < NUM_NIB; i++) begin
            if (sr_q[TIME_W + NIB_W * i +: NIB_W] >= 4'd5) begin
                sr_adj[TIME_W + NIB_W * i +: NIB_W] = sr_q[TIME_W + NIB_W * i +: NIB_W] + 4'd3;
            end
        end
        sr_shift = {sr_adj[SR_W-2:0], 1'b0};
    end

    // Sequencing: load on start, shift TIME_W times, latch the result.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        done_d  = 1'b0;
        hund_d  = hund_q;
        tens_d  = tens_q;
        units_d = units_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            sr_d   = {(NUM_NIB * NIB_W)'(0), bin};
        end else if (busy_q) begin
            sr_d   = sr_shift;
            cnt_d  = cnt_q + CNT_W'(1);
            done_d = (cnt_q == CNT_W'(TIME_W - 2));
            if (cnt_q == CNT_W'(TIME_W - 1)) begin
                busy_d  = 1'b0;
                hund_d  = (sr_shift[SR_W-1 -: NIB_W] != 4'd0) ? 4'hF
                                                               : sr_shift[TIME_W + 2 * NIB_W +: NIB_W];
                tens_d  = sr_shift[TIME_W + NIB_W +: NIB_W];
                units_d = sr_shift[TIME_W +: NIB_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            sr_q    <= '0;
            done_q  <= 1'b0;
            hund_q  <= '0;
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign done     = done_q;
    assign hundreds = hund_q;
    assign tens     = tens_q;
    assign units    = units_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 16-digit seven-segment driver for the eight traffic countdowns.
// Ports:
//   sys_clk, sys_rst  clock, asynchronous active-high reset
//   time_bus          8 x 10-bit countdowns, channel k on [10k+9:10k]
//   disp_en           0 blanks every digit; scanning/conversion carry on
//   sel               active-low one-hot digit select (2k tens, 2k+1 units)
//   seg               active-low segments {dp,g,f,e,d,c,b,a}
//   frame_sync        one-cycle pulse when a new snapshot is taken
// A snapshot of time_bus is taken once per scan frame (and right after
// reset), each channel is converted to BCD in turn and stored as segment
// codes; the display only ever reads the stored codes.
module seg_scan_driver
    import traffic_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [NUM_CH*TIME_W-1:0] time_bus,
    input  logic                     disp_en,
    output logic [NUM_DIG-1:0]       sel,
    output logic [7:0]               seg,
    output logic                     frame_sync
);

    localparam int unsigned PRESC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W    = $clog2(NUM_DIG);
    localparam int unsigned CH_IDX_W = $clog2(NUM_CH);
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_DIG - 1);
    localparam logic [CH_IDX_W-1:0] CH_LAST   = CH_IDX_W'(NUM_CH - 1);

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]    digit_idx_q, digit_idx_d;
    logic                first_q;
    logic [TIME_W-1:0]   snap_q [NUM_CH];
    logic [TIME_W-1:0]   snap_d [NUM_CH];
    logic                frame_sync_q, frame_sync_d;
    conv_state_e         state_q, state_d;
    logic [CH_IDX_W-1:0] ch_q, ch_d;
    logic [15:0]         bcd_q [NUM_CH];
    logic [15:0]         bcd_d [NUM_CH];
    logic [NUM_DIG-1:0]  sel_q, sel_d;
    logic [7:0]          seg_q, seg_d;

    logic                tick_c;
    logic                snap_take_c;
    logic                cv_start_c;
    logic [TIME_W-1:0]   cv_bin_c;
    logic                cv_done;
    logic [3:0]          cv_hund;
    logic [3:0]          cv_tens;
    logic [3:0]          cv_units;
    logic [7:0]          tens_code_c;
    logic [15:0]         pair_code_c;

    bin2bcd_seq u_bin2bcd (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .bin      (cv_bin_c),
        .start    (cv_start_c),
        .done     (cv_done),
        .hundreds (cv_hund),
        .tens     (cv_tens),
        .units    (cv_units)
    );

    assign cv_bin_c = snap_q[ch_q];

    // Digit-slot prescaler and scan position.
    always_comb begin
        tick_c      = (presc_q == PRESC_MAX);
        presc_d     = tick_c ? '0 : presc_q + PRESC_W'(1);
        digit_idx_d = tick_c ? digit_idx_q + IDX_W'(1) : digit_idx_q;
    end

    // Snapshot on the 15->0 wrap or straight after reset; dropped if busy.
    always_comb begin
        snap_take_c  = (first_q || (tick_c && (digit_idx_q == IDX_LAST)))
                       && (state_q == ST_IDLE);
        snap_d       = snap_q;
        frame_sync_d = 1'b0;
        if (snap_take_c) begin
            frame_sync_d = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                snap_d[i] = time_bus[i * TIME_W +: TIME_W];
            end
        end
    end

    // Converter result to {tens,units} segment codes.
    always_comb begin
        tens_code_c = (LZ_BLANK && (cv_tens == 4'd0)) ? SEG_BLANK : seg_encode(cv_tens);
        pair_code_c = {tens_code_c, seg_encode(cv_units)};
        if (cv_hund != 4'd0) begin
            pair_code_c = {SEG_DASH, SEG_DASH};
        end
    end

    // Conversion sequencer: walk the eight channels through the converter.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        bcd_d      = bcd_q;
        cv_start_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (snap_take_c) begin
                    state_d = ST_LOAD;
                    ch_d    = '0;
                end
            end
            ST_LOAD: begin
                cv_start_c = 1'b1;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cv_done) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                bcd_d[ch_q] = pair_code_c;
                if (ch_q == CH_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = ch_q + CH_IDX_W'(1);
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Display register: reload on tick from the new slot, blank when disabled.
    always_comb begin
        sel_d = sel_q;
        seg_d = seg_q;
        if (!disp_en) begin
            sel_d = '1;
            seg_d = SEG_BLANK;
        end else if (tick_c) begin
            sel_d = ~(NUM_DIG'(1) << digit_idx_d);
            seg_d = digit_idx_d[0] ? bcd_q[digit_idx_d[IDX_W-1:1]][7:0]
                                   : bcd_q[digit_idx_d[IDX_W-1:1]][15:8];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            presc_q      <= '0;
            digit_idx_q  <= '0;
            first_q      <= 1'b1;
            frame_sync_q <= 1'b0;
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            sel_q        <= '1;
            seg_q        <= SEG_BLANK;
            for (int i = 0; i < NUM_CH; i++) begin
                snap_q[i] <= '0;
                bcd_q[i]  <= {SEG_BLANK, SEG_BLANK};
            end
        end else begin
            presc_q      <= presc_d;
            digit_idx_q  <= digit_idx_d;
            first_q      <= 1'b0;
            frame_sync_q <= frame_sync_d;
            state_q      <= state_d;
            ch_q         <= ch_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
            for (int i = 0; i < NUM_CH; i++) begin
                snap_q[i] <= snap_d[i];
                bcd_q[i]  <= bcd_d[i];
            end
        end
    end

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign frame_sync = frame_sync_q;

endmodule
